// File: rtl/uart_pkg.sv
// Shared types and constants for the streaming UART transmitter.
// Parity and framing-state enums plus the legal payload width range.
package uart_pkg;

   localparam int DATA_BITS_MIN = 5;
   localparam int DATA_BITS_MAX = 9;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // The reserved encoding behaves like "no parity".
   function automatic parity_e decode_parity(input logic [1:0] m);
      return (m == 2'd3) ? PAR_NONE : parity_e'(m);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous single-clock FIFO with occupancy count.
// Power-of-two depth so the pointers wrap for free.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign full_o  = count_q[AW];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter: stream-fed FIFO, baud counter and framing FSM.
// Divisor, parity and stop count are captured at each frame start.
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DVSR_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DVSR_W-1:0]             dvsr,
   input  logic [1:0]                    parity_mode,
   input  logic                          two_stop,
   input  logic [DATA_BITS-1:0]          wr_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_bits
      $error("DATA_BITS out of range");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end

   localparam logic [3:0]        LAST    = 4'(DATA_BITS - 1);
   localparam logic [DVSR_W-1:0] CNT_ONE = DVSR_W'(1);

   tx_state_e            state_q, state_d;
   logic [DVSR_W-1:0]    cnt_q, cnt_d;
   logic [DVSR_W-1:0]    dvsr_q, dvsr_d;
   parity_e              par_q, par_d;
   logic                 two_q, two_d;
   logic                 stop2_q, stop2_d;
   logic                 parbit_q, parbit_d;
   logic                 tx_q, tx_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic [DATA_BITS-1:0] head;
   logic                 load, tick, empty, full;

   uart_tx_fifo #(
      .W     (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (wr_valid),
      .pop_i   (load),
      .wdata_i (wr_data),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count)
   );

   assign wr_ready = !full;
   assign tick     = (cnt_q == dvsr_q);
   assign busy     = (state_q != IDLE);
   assign tx       = tx_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = tick ? '0 : cnt_q + CNT_ONE;
      dvsr_d   = dvsr_q;
      par_d    = par_q;
      two_d    = two_q;
      stop2_d  = stop2_q;
      parbit_d = parbit_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      load     = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            load  = !empty;
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_q == LAST) begin
                  state_d = (par_q == PAR_NONE) ? STOP : PARITY;
                  stop2_d = 1'b0;
               end else begin
                  bit_d = bit_q + 4'd1;
                  sh_d  = sh_q >> 1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               stop2_d = 1'b0;
            end
         end
         STOP: begin
            if (tick) begin
               if (two_q && !stop2_q) stop2_d = 1'b1;
               else if (!empty)       load    = 1'b1;
               else                   state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame start, from IDLE or straight out of the last stop bit.
      if (load) begin
         state_d  = START;
         cnt_d    = '0;
         dvsr_d   = dvsr;
         par_d    = decode_parity(parity_mode);
         two_d    = two_stop;
         stop2_d  = 1'b0;
         sh_d     = head;
         parbit_d = (^head) ^ (par_d == PAR_ODD);
      end

      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[0];
         PARITY:  tx_d = parbit_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvsr_q   <= '0;
         par_q    <= PAR_NONE;
         two_q    <= 1'b0;
         stop2_q  <= 1'b0;
         parbit_q <= 1'b0;
         tx_q     <= 1'b1;
         bit_q    <= '0;
         sh_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvsr_q   <= dvsr_d;
         par_q    <= par_d;
         two_q    <= two_d;
         stop2_q  <= stop2_d;
         parbit_q <= parbit_d;
         tx_q     <= tx_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
      end
   end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmit subsystem: a free-running-clock baud generator, a synchronous transmit FIFO and a framing state machine in one `clk` domain. The baud tick is a clock enable, not a derived clock. The block accepts bytes on a valid/ready stream and serialises them with runtime-selectable divisor, parity and stop-bit count. It replaces the fixed 8N1, fixed-divisor transmitter top as the serial output stage of the system.

## Interface
- `DATA_BITS`, default 8: payload bits per frame; legal range 5..9.
- `FIFO_DEPTH`, default 16: transmit FIFO entries; must be a power of two, at least 2.
- `DVSR_W`, default 16: width of the baud divisor.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `dvsr` in DVSR_W: bit period in clocks is dvsr+1.
- `parity_mode` in 2: 0 = none, 1 = even, 2 = odd, 3 = reserved (treated as none).
- `two_stop` in 1: 0 = one stop bit, 1 = two stop bits.
- `wr_data` in DATA_BITS: byte to transmit.
- `wr_valid` in 1: `wr_data` is valid.
- `wr_ready` out 1: FIFO not full; a transfer occurs when `wr_valid && wr_ready`.
- `tx` out 1: serial line; idle high.
- `busy` out 1: a frame is in progress.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.

## Operation
- Reset values:
  - `tx`=1, `busy`=0, `wr_ready`=1, `fifo_count`=0.
  - FIFO pointers are 0 and the FSM is in IDLE.
  - The baud counter is 0.
- FSM states:
  - IDLE -> START when the FIFO is non-empty. The head entry is popped, and `dvsr`, `parity_mode` and `two_stop` are latched.
  - START -> DATA: `tx`=0 for one bit.
  - DATA: sends `DATA_BITS` bits, LSB first, using an internal bit index.
  - DATA -> PARITY if the latched mode is even or odd; otherwise DATA -> STOP.
  - PARITY: even mode sends the XOR of the data bits; odd mode sends its inverse.
  - STOP: `tx`=1 for one bit, or two bits if `two_stop` was latched.
  - STOP -> START directly if the FIFO is non-empty at the end of the last stop bit (back-to-back frames, no idle gap); otherwise STOP -> IDLE.
- Baud counter:
  - Cleared on entry to START.
  - Counts 0..latched dvsr; the bit-end strobe fires when the counter equals the latched dvsr.
  - Held at 0 in IDLE.
  - `dvsr`=0 gives one clock per bit.
- Configuration inputs are sampled only at frame start. Changing them mid-frame has no effect until the next frame.
- FIFO behaviour:
  - `wr_ready` = !full, registered from the occupancy.
  - A write while full is not accepted, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `busy` is high in every state except IDLE.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). Queued data is discarded.

## Timing
- A `wr_valid` handshake in cycle N, with the FIFO empty and the FSM in IDLE:
  - `fifo_count`=1 in N+1, and the FSM pops in N+1.
  - `tx` falls and `busy` rises in N+2.
  - `fifo_count` returns to 0 in N+2.
- Each bit lasts exactly dvsr+1 clocks.
- Frame length in clocks = (1 + DATA_BITS + P + S) × (dvsr+1), where P is 1 if parity is enabled else 0, and S is 1 or 2.
- In back-to-back frames, the next start bit begins on the clock immediately after the last stop-bit clock.
- `tx` is driven from a flop; no combinational path exists from any input to `tx`.

## Structure
- Package `uart_pkg`:
  - `parity_e` (PAR_NONE, PAR_EVEN, PAR_ODD).
  - `tx_state_e` (IDLE, START, DATA, PARITY, STOP).
  - Legal-range constants for `DATA_BITS`.
- Sub-module `uart_tx_fifo`: parametrised synchronous FIFO with `push`, `pop`, `full`, `empty` and `count`; one flop-array memory.
- Baud counter and framing FSM live in the top module `uart_tx_stream`.

## Test plan
- Reset, then `dvsr`=3, 8N1, write 0xA5:
  - `tx` sequence per 4-clock bit: 0,1,0,1,0,0,1,0,1,1.
  - 40 clocks total.
  - `busy` falls after the stop bit.
- Parity on 0xA5 (four ones):
  - Even parity gives parity bit 0; odd gives 1.
  - With `two_stop`=1, the frame is 12 bits = 48 clocks at `dvsr`=3.
- Back-to-back frames: write 0x01 then 0x80 on consecutive cycles.
  - The second start bit follows the first stop bit with no idle clock.
  - `fifo_count` goes 1, 1, 0.
- Overflow: `dvsr`=100, hold `wr_valid` high for 20 cycles.
  - Exactly 17 bytes are accepted: 16 in the FIFO plus 1 popped.
  - `wr_ready` stays low until the next pop.
- Mid-frame changes:
  - Changing `dvsr` from 3 to 7 mid-frame keeps 4-clock bits until the frame ends; the next frame uses 8-clock bits.
  - Asserting `rst_n`=0 mid-frame gives `tx`=1, `busy`=0, `fifo_count`=0 within the same cycle.
- `dvsr`=0, `DATA_BITS`=5, write 0x1F: 7 one-clock bits, 0,1,1,1,1,1,1.
